// File: rtl/conv2_pkg.sv
// -----------------------------------------------------------------------------
// conv2_pkg
// Shared constants and types for the conv2 filter scheduler.
//   CHANNEL_LEN  output filters time-sharing one convolution-sum datapath
//   FILTER_SIZE  kernel edge length (5x5 windows)
//   DATA_W       width of the signed datapath result
//   state_t      scheduler FSM encoding (IDLE / ISSUE / WAIT)
// -----------------------------------------------------------------------------
package conv2_pkg;

  localparam int CHANNEL_LEN = 3;
  localparam int FILTER_SIZE = 5;
  localparam int DATA_W      = 14;
  localparam int CH_W        = 2;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/conv2_sched_if.sv
// -----------------------------------------------------------------------------
// conv2_sched_if
// Bundles the window handshake, datapath issue/return and result/status
// signals of the conv2 scheduler.
//   slave  : scheduler view (accepts windows, issues to datapath, emits results)
//   master : environment view (window buffer, datapath and max-pool side)
// Parameters OUT_W / OUT_H size the out_col / out_row fields.
// -----------------------------------------------------------------------------
interface conv2_sched_if #(
  parameter int OUT_W = 8,
  parameter int OUT_H = 8
);
  import conv2_pkg::*;

  localparam int COL_W = $clog2(OUT_W);
  localparam int ROW_W = $clog2(OUT_H);

  logic             win_valid;
  logic             win_ready;
  logic             calc_start;
  logic [CH_W-1:0]  filt_sel;
  logic             calc_valid;
  data_t            calc_data;
  logic             out_valid;
  data_t            out_data;
  logic [CH_W-1:0]  out_ch;
  logic [COL_W-1:0] out_col;
  logic [ROW_W-1:0] out_row;
  logic             frame_done;
  logic             err_tmo;
  logic             err_spur;

  modport slave (
    input  win_valid, calc_valid, calc_data,
    output win_ready, calc_start, filt_sel, out_valid, out_data,
           out_ch, out_col, out_row, frame_done, err_tmo, err_spur
  );

  modport master (
    output win_valid, calc_valid, calc_data,
    input  win_ready, calc_start, filt_sel, out_valid, out_data,
           out_ch, out_col, out_row, frame_done, err_tmo, err_spur
  );

endinterface

// File: rtl/conv2_pos_cnt.sv
// -----------------------------------------------------------------------------
// conv2_pos_cnt
// Output-position counter for the conv2 feature map (raster order).
//   clk, rst_n    clock / asynchronous active-low reset
//   i_adv         advance to the next window position
//   o_col, o_row  current position
//   o_frame_wrap  current position is the last one of the frame
// -----------------------------------------------------------------------------
module conv2_pos_cnt #(
  parameter int OUT_W = 8,
  parameter int OUT_H = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_adv,
  output logic [$clog2(OUT_W)-1:0] o_col,
  output logic [$clog2(OUT_H)-1:0] o_row,
  output logic                     o_frame_wrap
);

  localparam int COL_W = $clog2(OUT_W);
  localparam int ROW_W = $clog2(OUT_H);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             w_col_last;
  logic             w_row_last;

  assign w_col_last   = (r_col == COL_W'(OUT_W - 1));
  assign w_row_last   = (r_row == ROW_W'(OUT_H - 1));
  assign o_frame_wrap = w_col_last && w_row_last;
  assign o_col        = r_col;
  assign o_row        = r_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv2_sched.sv
// -----------------------------------------------------------------------------
// conv2_sched
// Time-multiplexes the conv2 convolution-sum datapath across CHANNEL_LEN
// output filters. Each accepted 5x5 window is issued once per filter
// (filt_sel 0..CHANNEL_LEN-1); every returned sum is registered and tagged
// with its channel and output position for the max-pool stage.
//   clk, rst_n   clock / asynchronous active-low reset
//   bus (slave)  win_valid/win_ready   window handshake (ready only in IDLE)
//                calc_start/filt_sel   one-cycle issue to datapath + bank
//                calc_valid/calc_data  datapath result return
//                out_valid/out_data/out_ch/out_col/out_row  tagged result
//                frame_done            last position of the frame finished
//                err_tmo / err_spur    sticky timeout / spurious-result flags
// Parameters: OUT_W, OUT_H (map size), CALC_LAT (nominal datapath latency),
//             TMO_SLACK (extra cycles tolerated before timeout).
// Build option: define CONV2_SCHED_RELU_EN to clamp negative results to 0.
// -----------------------------------------------------------------------------
module conv2_sched
  import conv2_pkg::*;
#(
  parameter int OUT_W     = 8,
  parameter int OUT_H     = 8,
  parameter int CALC_LAT  = 2,
  parameter int TMO_SLACK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  conv2_sched_if.slave  bus
);

  localparam int COL_W   = $clog2(OUT_W);
  localparam int ROW_W   = $clog2(OUT_H);
  localparam int TMO_LIM = CALC_LAT + TMO_SLACK;
  localparam int CNT_W   = $clog2(TMO_LIM + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNEL_LEN - 1);

  function automatic data_t clamp_out(input data_t d);
`ifdef CONV2_SCHED_RELU_EN
    return (d < 0) ? '0 : d;
`else
    return d;
`endif
  endfunction

  state_t           r_state;
  logic [CH_W-1:0]  r_ch;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_calc_start;
  logic             r_out_valid;
  data_t            r_out_data;
  logic [CH_W-1:0]  r_out_ch;
  logic [COL_W-1:0] r_out_col;
  logic [ROW_W-1:0] r_out_row;
  logic             r_frame_done;
  logic             r_err_tmo;
  logic             r_err_spur;

  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_frame_wrap;
  logic             w_in_wait;
  logic             w_last_accept;
  logic             w_tmo;
  logic             w_adv;

  assign w_in_wait     = (r_state == ST_WAIT);
  assign w_last_accept = w_in_wait && bus.calc_valid && (r_ch == LAST_CH);
  // Timeout fires on the WAIT cycle where the counter has reached TMO_LIM-1,
  // i.e. after TMO_LIM cycles in WAIT; a result arriving on that same cycle wins.
  assign w_tmo         = w_in_wait && !bus.calc_valid && (r_wait_cnt == CNT_W'(TMO_LIM - 1));
  assign w_adv         = w_last_accept || w_tmo;

  conv2_pos_cnt #(
    .OUT_W (OUT_W),
    .OUT_H (OUT_H)
  ) u_pos_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_adv        (w_adv),
    .o_col        (w_col),
    .o_row        (w_row),
    .o_frame_wrap (w_frame_wrap)
  );

  assign bus.win_ready  = (r_state == ST_IDLE);
  assign bus.filt_sel   = (r_state == ST_IDLE) ? '0 : r_ch;
  assign bus.calc_start = r_calc_start;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_ch     = r_out_ch;
  assign bus.out_col    = r_out_col;
  assign bus.out_row    = r_out_row;
  assign bus.frame_done = r_frame_done;
  assign bus.err_tmo    = r_err_tmo;
  assign bus.err_spur   = r_err_spur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ch         <= '0;
      r_wait_cnt   <= '0;
      r_calc_start <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_out_col    <= '0;
      r_out_row    <= '0;
      r_frame_done <= 1'b0;
      r_err_tmo    <= 1'b0;
      r_err_spur   <= 1'b0;
    end else begin
      r_calc_start <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;

      // A result outside WAIT has no issue to belong to: flag and drop it.
      if (bus.calc_valid && !w_in_wait) begin
        r_err_spur <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.win_valid) begin
            r_ch         <= '0;
            r_calc_start <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (bus.calc_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= clamp_out(bus.calc_data);
            r_out_ch    <= r_ch;
            r_out_col   <= w_col;
            r_out_row   <= w_row;
            if (r_ch == LAST_CH) begin
              r_frame_done <= w_frame_wrap;
              r_state      <= ST_IDLE;
            end else begin
              r_ch         <= r_ch + 1'b1;
              r_calc_start <= 1'b1;
              r_state      <= ST_ISSUE;
            end
          end else if (w_tmo) begin
            // Abandon the rest of this window; its position is still consumed.
            r_err_tmo    <= 1'b1;
            r_frame_done <= w_frame_wrap;
            r_state      <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2_sched.sv
module tb_conv2_sched;
  import conv2_pkg::*;

  localparam int OUT_W     = 8;
  localparam int OUT_H     = 8;
  localparam int CALC_LAT  = 2;
  localparam int TMO_SLACK = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv2_sched_if #(.OUT_W(OUT_W), .OUT_H(OUT_H)) bus_if ();

  conv2_sched #(
    .OUT_W     (OUT_W),
    .OUT_H     (OUT_H),
    .CALC_LAT  (CALC_LAT),
    .TMO_SLACK (TMO_SLACK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Datapath results per filter bank, hand-chosen: typical, negative, max positive.
  data_t tbl [4];
  initial begin
    tbl[0] = 14'sd100;
    tbl[1] = -14'sd5;
    tbl[2] = 14'sd8191;
    tbl[3] = 14'sd0;
  end

  function automatic int exp_data(input int ch);
`ifdef CONV2_SCHED_RELU_EN
    if (ch == 1) return 0;
`endif
    if (ch == 0) return 100;
    if (ch == 1) return -5;
    return 8191;
  endfunction

  // Datapath stand-in: returns tbl[filt_sel] CALC_LAT cycles after calc_start.
  bit emu_en      = 1'b1;
  int emu_drop_ch = -1;
  initial begin
    logic [CALC_LAT:0] vpipe;
    logic [1:0]        cpipe [CALC_LAT+1];
    vpipe = '0;
    for (int i = 0; i <= CALC_LAT; i++) cpipe[i] = '0;
    bus_if.calc_valid = 1'b0;
    bus_if.calc_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vpipe = '0;
      end else begin
        for (int i = CALC_LAT; i > 0; i--) begin
          vpipe[i] = vpipe[i-1];
          cpipe[i] = cpipe[i-1];
        end
        vpipe[0] = bus_if.calc_start;
        cpipe[0] = bus_if.filt_sel;
      end
      if (emu_en) begin
        bus_if.calc_valid = vpipe[CALC_LAT] && (int'(cpipe[CALC_LAT]) != emu_drop_ch);
        bus_if.calc_data  = vpipe[CALC_LAT] ? tbl[cpipe[CALC_LAT]] : '0;
      end
    end
  end

  // Output monitor.
  typedef struct {
    int data;
    int ch;
    int col;
    int row;
  } rec_t;
  rec_t q[$];
  rec_t fd_rec;
  int   fd_cnt    = 0;
  int   start_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.out_valid)
        q.push_back('{int'(bus_if.out_data), int'(bus_if.out_ch),
                      int'(bus_if.out_col), int'(bus_if.out_row)});
      if (bus_if.frame_done) begin
        fd_cnt++;
        fd_rec = '{int'(bus_if.out_data), int'(bus_if.out_ch),
                   int'(bus_if.out_col), int'(bus_if.out_row)};
      end
      if (bus_if.calc_start) start_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    q.delete();
    fd_cnt = 0;
  endtask

  // Issue one window and wait until the scheduler is idle again.
  task automatic run_window(input string tag);
    bit done;
    bus_if.win_valid = 1'b1;
    tick();
    bus_if.win_valid = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (bus_if.win_ready) done = 1'b1;
      else tick();
    end
    if (!done) check_val({tag, "_idle_timeout"}, 0, 1);
    tick();
  endtask

  task automatic wait_issue_ch(input string tag, input int ch);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (bus_if.calc_start && int'(bus_if.filt_sel) == ch) seen = 1'b1;
      else tick();
    end
    if (!seen) check_val({tag, "_issue_timeout"}, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int s0;
    int accepts;
    int bad;
    bit fin;

    bus_if.win_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset state
    check_val("rst_win_ready",  int'(bus_if.win_ready), 1);
    check_val("rst_calc_start", int'(bus_if.calc_start), 0);
    check_val("rst_filt_sel",   int'(bus_if.filt_sel), 0);
    check_val("rst_out_valid",  int'(bus_if.out_valid), 0);
    check_val("rst_out_data",   int'(bus_if.out_data), 0);
    check_val("rst_err_tmo",    int'(bus_if.err_tmo), 0);
    check_val("rst_err_spur",   int'(bus_if.err_spur), 0);
    check_val("rst_frame_done", int'(bus_if.frame_done), 0);

    // Test 1: issue timing, accept in cycle 0
    rst_n = 1'b1;
    bus_if.win_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) bus_if.win_valid = 1'b0;
      check_val($sformatf("t1_calc_start_c%0d", k), int'(bus_if.calc_start),
                (k == 1 || k == 4 || k == 7) ? 1 : 0);
      if (k == 1 || k == 4 || k == 7)
        check_val($sformatf("t1_filt_sel_c%0d", k), int'(bus_if.filt_sel), (k - 1) / 3);
      check_val($sformatf("t1_win_ready_c%0d", k), int'(bus_if.win_ready), (k == 10) ? 1 : 0);
    end
    tick();

    // Test 2: result values and tags
    check_val("t2_count", q.size(), 3);
    if (q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check_val($sformatf("t2_data%0d", i), q[i].data, exp_data(i));
        check_val($sformatf("t2_ch%0d", i),   q[i].ch, i);
        check_val($sformatf("t2_pos%0d", i),  q[i].col + q[i].row, 0);
      end
    end

    // Test 3: full frame, back to back
    do_reset();
    accepts = 0;
    fin = 1'b0;
    bus_if.win_valid = 1'b1;
    for (int c = 0; c < 800 && !fin; c++) begin
      if (bus_if.win_ready) begin
        if (accepts == 64) begin
          bus_if.win_valid = 1'b0;
          fin = 1'b1;
        end else begin
          accepts++;
        end
      end
      if (!fin) tick();
    end
    bus_if.win_valid = 1'b0;
    if (!fin) check_val("t3_frame_timeout", accepts, 64);
    repeat (2) tick();
    check_val("t3_out_count", q.size(), 192);
    check_val("t3_frame_done_count", fd_cnt, 1);
    check_val("t3_fd_ch",  fd_rec.ch, 2);
    check_val("t3_fd_col", fd_rec.col, 7);
    check_val("t3_fd_row", fd_rec.row, 7);
    bad = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].ch != i % 3 || q[i].col != (i / 3) % 8 || q[i].row != (i / 3) / 8 ||
          q[i].data != exp_data(i % 3))
        bad++;
    end
    check_val("t3_sequence_errors", bad, 0);
    n0 = q.size();
    run_window("t3_wrap");
    check_val("t3_wrap_count", q.size() - n0, 3);
    if (q.size() > n0) begin
      check_val("t3_wrap_col", q[n0].col, 0);
      check_val("t3_wrap_row", q[n0].row, 0);
    end

    // Test 4: datapath never answers ch1 -> timeout; position now (1,0)
    emu_drop_ch = 1;
    n0 = q.size();
    s0 = start_cnt;
    bus_if.win_valid = 1'b1;
    tick();
    bus_if.win_valid = 1'b0;
    wait_issue_ch("t4", 1);
    repeat (6) tick();
    check_val("t4_err_tmo_wait6", int'(bus_if.err_tmo), 0);
    tick();
    check_val("t4_err_tmo_set", int'(bus_if.err_tmo), 1);
    check_val("t4_idle_after_tmo", int'(bus_if.win_ready), 1);
    repeat (10) tick();
    check_val("t4_issues", start_cnt - s0, 2);
    check_val("t4_out_count", q.size() - n0, 1);
    if (q.size() > n0) begin
      check_val("t4_ch0_col", q[n0].col, 1);
      check_val("t4_ch0_ch",  q[n0].ch, 0);
    end
    check_val("t4_err_tmo_sticky", int'(bus_if.err_tmo), 1);
    emu_drop_ch = -1;
    n0 = q.size();
    run_window("t4_next");
    check_val("t4_next_count", q.size() - n0, 3);
    if (q.size() > n0) begin
      check_val("t4_next_col", q[n0].col, 2);
      check_val("t4_next_row", q[n0].row, 0);
    end
    check_val("t4_no_frame_done", fd_cnt, 1);

    // Test 5: spurious result while idle
    emu_en = 1'b0;
    n0 = q.size();
    s0 = start_cnt;
    check_val("t5_spur_before", int'(bus_if.err_spur), 0);
    bus_if.calc_valid = 1'b1;
    bus_if.calc_data  = 14'sd77;
    tick();
    bus_if.calc_valid = 1'b0;
    bus_if.calc_data  = '0;
    repeat (2) tick();
    emu_en = 1'b1;
    check_val("t5_err_spur", int'(bus_if.err_spur), 1);
    check_val("t5_no_out", q.size() - n0, 0);
    check_val("t5_still_idle", int'(bus_if.win_ready), 1);
    check_val("t5_no_issue", start_cnt - s0, 0);

    // Test 6: reset in the middle of WAIT for ch1
    bus_if.win_valid = 1'b1;
    tick();
    bus_if.win_valid = 1'b0;
    wait_issue_ch("t6", 1);
    tick();
    rst_n = 1'b0;
    #1;
    check_val("t6_win_ready",  int'(bus_if.win_ready), 1);
    check_val("t6_filt_sel",   int'(bus_if.filt_sel), 0);
    check_val("t6_calc_start", int'(bus_if.calc_start), 0);
    check_val("t6_err_tmo",    int'(bus_if.err_tmo), 0);
    check_val("t6_err_spur",   int'(bus_if.err_spur), 0);
    check_val("t6_out_valid",  int'(bus_if.out_valid), 0);
    check_val("t6_out_col",    int'(bus_if.out_col), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n0 = q.size();
    bus_if.win_valid = 1'b1;
    tick();
    bus_if.win_valid = 1'b0;
    check_val("t6_restart_issue", int'(bus_if.calc_start), 1);
    check_val("t6_restart_filt",  int'(bus_if.filt_sel), 0);
    for (int c = 0; c < 20 && !bus_if.win_ready; c++) tick();
    tick();
    check_val("t6_restart_count", q.size() - n0, 3);
    if (q.size() > n0) begin
      check_val("t6_restart_col", q[n0].col, 0);
      check_val("t6_restart_row", q[n0].row, 0);
      check_val("t6_restart_ch",  q[n0].ch, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
